// File: rtl/seven_seg_scan.sv
// Time-multiplexed N-digit common-anode seven-segment driver.
// Provides a refresh prescaler, per-digit blanking, anode dead time and a tear-free double-buffered load.

module seven_seg_lane (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic       xfer,
    input  logic [3:0] dig_in,
    input  logic       dp_in,
    input  logic       blank_in,
    output logic [3:0] dig,
    output logic       dp,
    output logic       blank
);
    // Each entry is packed as {blank, dp, nibble}.
    logic [5:0] pend_q, pend_d;
    logic [5:0] act_q, act_d;

    always_comb begin
        pend_d = load ? {blank_in, dp_in, dig_in} : pend_q;
        act_d  = xfer ? pend_q : act_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend_q <= '0;
            act_q  <= '0;
        end else begin
            pend_q <= pend_d;
            act_q  <= act_d;
        end
    end

    assign dig   = act_q[3:0];
    assign dp    = act_q[4];
    assign blank = act_q[5];
endmodule

module seven_seg_scan #(
    parameter int N_DIGITS  = 4,
    parameter int DIV       = 100000,
    parameter int BLANK_CYC = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        en,
    input  logic                        load,
    input  logic [4*N_DIGITS-1:0]       digits,
    input  logic [N_DIGITS-1:0]         dp_in,
    input  logic [N_DIGITS-1:0]         blank,
    output logic [N_DIGITS-1:0]         an,
    output logic [6:0]                  seg,
    output logic                        dp,
    output logic [$clog2(N_DIGITS)-1:0] digit_sel,
    output logic                        frame_done
);
    localparam int IW = $clog2(N_DIGITS);
    localparam int CW = $clog2(DIV);

    logic [CW-1:0]       cnt_q, cnt_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic                pend_valid_q, pend_valid_d;
    logic                wrap_q, wrap_d;
    logic [N_DIGITS-1:0] an_q, an_d;
    logic [6:0]          seg_q, seg_d;
    logic                dp_q, dp_d;
    logic [IW-1:0]       sel_q, sel_d;
    logic                fd_q, fd_d;

    logic [N_DIGITS-1:0][3:0] act_dig;
    logic [N_DIGITS-1:0]      act_dp;
    logic [N_DIGITS-1:0]      act_blank;

    logic slot_end, last_slot, wrap, xfer, dead, lit;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0: hex7 = 7'h40;
            4'h1: hex7 = 7'h79;
            4'h2: hex7 = 7'h24;
            4'h3: hex7 = 7'h30;
            4'h4: hex7 = 7'h19;
            4'h5: hex7 = 7'h12;
            4'h6: hex7 = 7'h02;
            4'h7: hex7 = 7'h78;
            4'h8: hex7 = 7'h00;
            4'h9: hex7 = 7'h10;
            4'hA: hex7 = 7'h08;
            4'hB: hex7 = 7'h03;
            4'hC: hex7 = 7'h46;
            4'hD: hex7 = 7'h21;
            4'hE: hex7 = 7'h06;
            default: hex7 = 7'h0E;
        endcase
    endfunction

    for (genvar k = 0; k < N_DIGITS; k++) begin : g_lane
        seven_seg_lane u_lane (
            .clk      (clk),
            .rst_n    (rst_n),
            .load     (load),
            .xfer     (xfer),
            .dig_in   (digits[4*k +: 4]),
            .dp_in    (dp_in[k]),
            .blank_in (blank[k]),
            .dig      (act_dig[k]),
            .dp       (act_dp[k]),
            .blank    (act_blank[k])
        );
    end

    always_comb begin
        slot_end  = (cnt_q == CW'(DIV - 1));
        last_slot = (idx_q == IW'(N_DIGITS - 1));
        wrap      = en && slot_end && last_slot;
        // Disabled edges also swap buffers, so a load while off is seen right away.
        xfer      = pend_valid_q && (wrap || !en);
        dead      = (cnt_q < CW'(BLANK_CYC));
        lit       = en && !dead && !act_blank[idx_q];

        cnt_d = cnt_q;
        idx_d = idx_q;
        if (en) begin
            cnt_d = slot_end ? '0 : cnt_q + CW'(1);
            if (slot_end)
                idx_d = last_slot ? '0 : idx_q + IW'(1);
        end

        pend_valid_d = load ? 1'b1 : (xfer ? 1'b0 : pend_valid_q);
        wrap_d       = wrap;

        an_d = '1;
        if (lit)
            an_d[idx_q] = 1'b0;
        seg_d = lit ? hex7(act_dig[idx_q]) : 7'h7F;
        dp_d  = lit ? ~act_dp[idx_q] : 1'b1;
        sel_d = idx_q;
        fd_d  = wrap_q && en;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            pend_valid_q <= 1'b0;
            wrap_q       <= 1'b0;
            an_q         <= '1;
            seg_q        <= 7'h7F;
            dp_q         <= 1'b1;
            sel_q        <= '0;
            fd_q         <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            pend_valid_q <= pend_valid_d;
            wrap_q       <= wrap_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            sel_q        <= sel_d;
            fd_q         <= fd_d;
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign dp         = dp_q;
    assign digit_sel  = sel_q;
    assign frame_done = fd_q;
endmodule

// File: tb/tb_seven_seg_scan.sv
// Scoreboard bench for seven_seg_scan (N_DIGITS=4, DIV=8, BLANK_CYC=2): per-cycle expected outputs queued, popped and compared.

module tb_seven_seg_scan;
    localparam int N     = 4;
    localparam int DIV   = 8;
    localparam int BLANK = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        load = 1'b0;
    logic [15:0] digits = '0;
    logic [3:0]  dp_in = '0;
    logic [3:0]  blank = '0;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic [1:0]  digit_sel;
    logic        frame_done;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic [1:0] sel;
        logic       fd;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    seven_seg_scan #(.N_DIGITS(N), .DIV(DIV), .BLANK_CYC(BLANK)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .load       (load),
        .digits     (digits),
        .dp_in      (dp_in),
        .blank      (blank),
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .digit_sel  (digit_sel),
        .frame_done (frame_done)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One slot: BLANK dead cycles, then the digit lit unless blanked.
    task automatic push_slot(input int i, input logic [6:0] s, input logic dl,
                             input logic blk, input logic fd);
        for (int c = 0; c < DIV; c++) begin
            exp_t e;
            e.an = 4'hF;
            if (c >= BLANK && !blk) e.an[i] = 1'b0;
            e.seg = (e.an == 4'hF) ? 7'h7F : s;
            e.dp  = (e.an == 4'hF) ? 1'b1 : ~dl;
            e.sel = 2'(i);
            e.fd  = fd && (c == 0);
            sb.push_back(e);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b1; load = 1'b1; digits = 16'hFFFF; dp_in = 4'hF;
        for (int j = 0; j < 3; j++) begin
            exp_t o;
            step();
            o = exp_t'({an, seg, dp, digit_sel, frame_done});
            checks++;
            if (o !== exp_t'({4'hF, 7'h7F, 1'b1, 2'd0, 1'b0})) begin
                errors++;
                $display("FAIL reset[%0d] got an=%h seg=%h dp=%b sel=%0d fd=%b want an=f seg=7f dp=1 sel=0 fd=0",
                         j, an, seg, dp, digit_sel, frame_done);
            end
        end
    endtask

    task automatic test_load_disabled();
        rst_n = 1'b1; en = 1'b0; load = 1'b1; digits = 16'h1234; dp_in = 4'b0001; blank = 4'b0000;
        for (int j = 0; j < 2; j++) begin
            exp_t o;
            step();
            load = 1'b0;
            o = exp_t'({an, seg, dp, digit_sel, frame_done});
            checks++;
            if (o !== exp_t'({4'hF, 7'h7F, 1'b1, 2'd0, 1'b0})) begin
                errors++;
                $display("FAIL disabled[%0d] got an=%h seg=%h dp=%b sel=%0d fd=%b want all off",
                         j, an, seg, dp, digit_sel, frame_done);
            end
        end
        en = 1'b1;
        push_slot(0, 7'h19, 1'b1, 1'b0, 1'b0);
        push_slot(1, 7'h30, 1'b0, 1'b0, 1'b0);
        for (int j = 0; sb.size() > 0; j++) begin
            exp_t e, o;
            step();
            e = sb.pop_front();
            o = exp_t'({an, seg, dp, digit_sel, frame_done});
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL first_slots[%0d] got an=%h seg=%h dp=%b sel=%0d fd=%b want an=%h seg=%h dp=%b sel=%0d fd=%b",
                         j, o.an, o.seg, o.dp, o.sel, o.fd, e.an, e.seg, e.dp, e.sel, e.fd);
            end
        end
    endtask

    task automatic test_free_run();
        int fd_cnt = 0;
        push_slot(2, 7'h24, 1'b0, 1'b0, 1'b0);
        push_slot(3, 7'h79, 1'b0, 1'b0, 1'b0);
        for (int f = 0; f < 3; f++) begin
            push_slot(0, 7'h19, 1'b1, 1'b0, 1'b1);
            push_slot(1, 7'h30, 1'b0, 1'b0, 1'b0);
            push_slot(2, 7'h24, 1'b0, 1'b0, 1'b0);
            push_slot(3, 7'h79, 1'b0, 1'b0, 1'b0);
        end
        for (int j = 0; sb.size() > 0; j++) begin
            exp_t e, o;
            step();
            e = sb.pop_front();
            o = exp_t'({an, seg, dp, digit_sel, frame_done});
            if (frame_done === 1'b1) fd_cnt++;
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL free_run[%0d] got an=%h seg=%h dp=%b sel=%0d fd=%b want an=%h seg=%h dp=%b sel=%0d fd=%b",
                         j, o.an, o.seg, o.dp, o.sel, o.fd, e.an, e.seg, e.dp, e.sel, e.fd);
            end
            checks++;
            if ($countones(~an) > 1) begin
                errors++;
                $display("FAIL anode_onehot[%0d] got an=%h want at most one low bit", j, an);
            end
        end
        checks++;
        if (fd_cnt !== 3) begin
            errors++;
            $display("FAIL frame_count got %0d want 3", fd_cnt);
        end
    endtask

    task automatic test_midframe_load();
        push_slot(0, 7'h19, 1'b1, 1'b0, 1'b1);
        push_slot(1, 7'h30, 1'b0, 1'b0, 1'b0);
        push_slot(2, 7'h24, 1'b0, 1'b0, 1'b0);
        push_slot(3, 7'h79, 1'b0, 1'b0, 1'b0);
        push_slot(0, 7'h21, 1'b0, 1'b0, 1'b1);
        push_slot(1, 7'h46, 1'b0, 1'b0, 1'b0);
        push_slot(2, 7'h03, 1'b0, 1'b0, 1'b0);
        push_slot(3, 7'h08, 1'b0, 1'b0, 1'b0);
        for (int j = 0; sb.size() > 0; j++) begin
            exp_t e, o;
            step();
            e = sb.pop_front();
            o = exp_t'({an, seg, dp, digit_sel, frame_done});
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL midframe_load[%0d] got an=%h seg=%h dp=%b sel=%0d fd=%b want an=%h seg=%h dp=%b sel=%0d fd=%b",
                         j, o.an, o.seg, o.dp, o.sel, o.fd, e.an, e.seg, e.dp, e.sel, e.fd);
            end
            if (j == 10) begin load = 1'b1; digits = 16'hABCD; dp_in = 4'b0000; end
            if (j == 11) load = 1'b0;
        end
    endtask

    task automatic test_blank();
        push_slot(0, 7'h21, 1'b0, 1'b0, 1'b1);
        push_slot(1, 7'h46, 1'b0, 1'b0, 1'b0);
        push_slot(2, 7'h03, 1'b0, 1'b0, 1'b0);
        push_slot(3, 7'h08, 1'b0, 1'b0, 1'b0);
        push_slot(0, 7'h21, 1'b0, 1'b0, 1'b1);
        push_slot(1, 7'h46, 1'b0, 1'b1, 1'b0);
        push_slot(2, 7'h03, 1'b0, 1'b0, 1'b0);
        push_slot(3, 7'h08, 1'b0, 1'b0, 1'b0);
        for (int j = 0; sb.size() > 0; j++) begin
            exp_t e, o;
            step();
            e = sb.pop_front();
            o = exp_t'({an, seg, dp, digit_sel, frame_done});
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL blank[%0d] got an=%h seg=%h dp=%b sel=%0d fd=%b want an=%h seg=%h dp=%b sel=%0d fd=%b",
                         j, o.an, o.seg, o.dp, o.sel, o.fd, e.an, e.seg, e.dp, e.sel, e.fd);
            end
            if (j == 2) begin load = 1'b1; blank = 4'b0010; end
            if (j == 3) load = 1'b0;
        end
    endtask

    task automatic test_pause_reset();
        exp_t off;
        off = exp_t'({4'hF, 7'h7F, 1'b1, 2'd2, 1'b0});
        push_slot(0, 7'h21, 1'b0, 1'b0, 1'b1);
        push_slot(1, 7'h46, 1'b0, 1'b1, 1'b0);
        push_slot(2, 7'h03, 1'b0, 1'b0, 1'b0);
        // Five frozen cycles inserted after slot 2 cycle 3.
        for (int k = 0; k < 5; k++) sb.insert(20, off);
        push_slot(3, 7'h08, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < DIV - 3; k++) void'(sb.pop_back());
        for (int j = 0; sb.size() > 0; j++) begin
            exp_t e, o;
            step();
            e = sb.pop_front();
            o = exp_t'({an, seg, dp, digit_sel, frame_done});
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL pause[%0d] got an=%h seg=%h dp=%b sel=%0d fd=%b want an=%h seg=%h dp=%b sel=%0d fd=%b",
                         j, o.an, o.seg, o.dp, o.sel, o.fd, e.an, e.seg, e.dp, e.sel, e.fd);
            end
            if (j == 19) en = 1'b0;
            if (j == 24) en = 1'b1;
        end
        rst_n = 1'b0;
        step();
        checks++;
        if (exp_t'({an, seg, dp, digit_sel, frame_done}) !== exp_t'({4'hF, 7'h7F, 1'b1, 2'd0, 1'b0})) begin
            errors++;
            $display("FAIL midscan_reset got an=%h seg=%h dp=%b sel=%0d fd=%b want an=f seg=7f dp=1 sel=0 fd=0",
                     an, seg, dp, digit_sel, frame_done);
        end
        // Buffers were cleared by reset, so slot 0 shows a zero digit.
        rst_n = 1'b1;
        push_slot(0, 7'h40, 1'b0, 1'b0, 1'b0);
        for (int j = 0; sb.size() > 0; j++) begin
            exp_t e, o;
            step();
            e = sb.pop_front();
            o = exp_t'({an, seg, dp, digit_sel, frame_done});
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL post_reset[%0d] got an=%h seg=%h dp=%b sel=%0d fd=%b want an=%h seg=%h dp=%b sel=%0d fd=%b",
                         j, o.an, o.seg, o.dp, o.sel, o.fd, e.an, e.seg, e.dp, e.sel, e.fd);
            end
        end
    endtask

    initial begin
        test_reset();
        test_load_disabled();
        test_free_run();
        test_midframe_load();
        test_blank();
        test_pause_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
